heatmap_argmax: RTL
===================

HEATMAP_ARGMAX -- requirements
Module: heatmap_argmax

Interface
REQ-001 Parameter: SCORE_W, 8, width of each heatmap score (unsigned).
REQ-002 Parameter: THRESH, 64, minimum winning score for a valid detection.
REQ-003 clk_in  input  1  system clock; the block has a single clock domain.
REQ-004 rst_in  input  1  reset, asynchronous and active-high.
REQ-005 score_valid_in  input  1  one heatmap cell presented this cycle.
REQ-006 score_in  input  SCORE_W  cell score.
REQ-007 hcount_in  input  5  cell column, 0..31.
REQ-008 vcount_in  input  5  cell row, 0..31.
REQ-009 data_valid_out  output  1  one-cycle pulse: the result is valid (feeds draw_box data_valid_in).
REQ-010 hcount_pred  output  5  column of the winning cell.
REQ-011 vcount_pred  output  5  row of the winning cell.
REQ-012 score_out  output  SCORE_W  winning score.
REQ-013 found_out  output  1  winning score >= THRESH; qualified by data_valid_out.
REQ-014 frame_err_out  output  1  one-cycle pulse: the frame was aborted because of a raster violation.

Function
REQ-015 Input is a 32x32 raster, row-major; cell (h,v) is expected at index v*32+h; cells arrive at one per valid cycle, with arbitrary gaps.
REQ-016 FSM states: IDLE, SCAN, EMIT.
REQ-017 IDLE: a valid cell at (0,0) loads the best registers with (score, 0, 0), sets expected index to 1, and moves to SCAN; any other valid cell is ignored silently.
REQ-018 SCAN: a valid cell matching the expected index updates best only if score_in > best score (strict, so ties keep the earliest cell in raster order); the expected index then increments.
REQ-019 SCAN: a valid cell at (0,0) that is not expected aborts the frame: pulse frame_err_out, then restart as in REQ-017 in the same cycle, with no data_valid_out.
REQ-020 SCAN: any other out-of-sequence cell pulses frame_err_out, discards the frame, and returns to IDLE.
REQ-021 SCAN: accepting the expected cell (31,31) with the best update folded in moves to EMIT; the comparison includes that last cell.
REQ-022 EMIT, one cycle: data_valid_out=1; hcount_pred, vcount_pred and score_out present the best cell; found_out=(best >= THRESH); next state is IDLE.
REQ-023 Latency: data_valid_out rises exactly 1 cycle after the clock edge that accepts cell (31,31).
REQ-024 A valid (0,0) arriving during EMIT is processed as in REQ-017 in that same cycle; the result is still emitted.
REQ-025 hcount_pred, vcount_pred, score_out and found_out are registered and hold their values until the next EMIT.
REQ-026 data_valid_out and frame_err_out are never high in the same cycle.
REQ-027 The expected-index counter is 10 bits and is never compared beyond 1023; comparisons are unsigned.

Reset
REQ-028 rst_in asynchronously forces: state IDLE, all outputs 0, best registers 0, expected index 0.
REQ-029 Reset asserted mid-frame discards the partial frame and emits no result or error pulse; the first frame accepted after release must start at (0,0).

Structure
REQ-030 A shared package (image_pkg) holds the GRID_W=32/GRID_H=32 constants, the 5-bit coordinate typedef, and the FSM state enum.
REQ-031 The block is a single module with no sub-modules; the compare/update logic is inline.

Verification
REQ-032 Full frame with all scores 0 except (7,12)=200 -> one data_valid_out, 1 cycle after (31,31); hcount_pred=7, vcount_pred=12, score_out=200, found_out=1.
REQ-033 Ties: (3,0)=90 and (5,9)=90, all others 10 -> pred (3,0), score_out=90, found_out=1.
REQ-034 Max 50 at (31,31), all others 0, with THRESH=64 -> pred (31,31), score_out=50, found_out=0.
REQ-035 Frame jumps from index 100 to 102 -> frame_err_out pulses once, no data_valid_out; a following clean frame gives the correct result.
REQ-036 rst_in pulsed at cell 500, then a clean frame with max at (0,31)=255 -> exactly one result, (0,31), score_out=255; no stale data from the first frame.
REQ-037 Back-to-back frames, with (0,0) of frame 2 arriving in the EMIT cycle of frame 1 -> both results are correct, with no frame_err_out.

Source files
------------

// File: rtl/image_pkg.sv
// image_pkg: shared raster geometry, coordinate type and argmax FSM states
package image_pkg;
    localparam int GRID_W = 32;
    localparam int GRID_H = 32;
    typedef logic [4:0] coord_t;
    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;
endpackage

// File: rtl/heatmap_argmax.sv
// heatmap_argmax: streams a 32x32 score raster and emits the location of its maximum
module heatmap_argmax
    import image_pkg::*;
#(
    parameter int SCORE_W = 8,
    parameter int THRESH  = 64
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               score_valid_in,
    input  logic [SCORE_W-1:0] score_in,
    input  coord_t             hcount_in,
    input  coord_t             vcount_in,
    output logic               data_valid_out,
    output coord_t             hcount_pred,
    output coord_t             vcount_pred,
    output logic [SCORE_W-1:0] score_out,
    output logic               found_out,
    output logic               frame_err_out
);
    localparam logic [SCORE_W-1:0] LP_THRESH = SCORE_W'(THRESH);
    localparam logic [9:0]         LP_LAST   = 10'(GRID_W * GRID_H - 1);

    state_t             r_state;
    logic [9:0]         r_exp;
    logic [SCORE_W-1:0] r_best_score;
    coord_t             r_best_h;
    coord_t             r_best_v;

    logic [9:0]         w_idx;
    logic               w_origin;
    logic               w_hit;
    logic               w_better;
    logic [SCORE_W-1:0] w_nb_score;
    coord_t             w_nb_h;
    coord_t             w_nb_v;

    // Strict compare keeps the earliest cell on ties; the folded best feeds the emit path directly
    assign w_idx      = {vcount_in, hcount_in};
    assign w_origin   = score_valid_in && (w_idx == 10'd0);
    assign w_hit      = score_valid_in && (w_idx == r_exp);
    assign w_better   = score_in > r_best_score;
    assign w_nb_score = w_better ? score_in  : r_best_score;
    assign w_nb_h     = w_better ? hcount_in : r_best_h;
    assign w_nb_v     = w_better ? vcount_in : r_best_v;

    // Frame sequencing, running argmax and registered result/error pulses
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state        <= IDLE;
            r_exp          <= '0;
            r_best_score   <= '0;
            r_best_h       <= '0;
            r_best_v       <= '0;
            data_valid_out <= 1'b0;
            frame_err_out  <= 1'b0;
            hcount_pred    <= '0;
            vcount_pred    <= '0;
            score_out      <= '0;
            found_out      <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            frame_err_out  <= 1'b0;
            case (r_state)
                IDLE, EMIT: begin
                    if (w_origin) begin
                        r_best_score <= score_in;
                        r_best_h     <= '0;
                        r_best_v     <= '0;
                        r_exp        <= 10'd1;
                        r_state      <= SCAN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SCAN: begin
                    if (w_hit) begin
                        r_best_score <= w_nb_score;
                        r_best_h     <= w_nb_h;
                        r_best_v     <= w_nb_v;
                        if (r_exp == LP_LAST) begin
                            r_state        <= EMIT;
                            data_valid_out <= 1'b1;
                            hcount_pred    <= w_nb_h;
                            vcount_pred    <= w_nb_v;
                            score_out      <= w_nb_score;
                            found_out      <= w_nb_score >= LP_THRESH;
                        end else begin
                            r_exp <= r_exp + 10'd1;
                        end
                    end else if (w_origin) begin
                        frame_err_out <= 1'b1;
                        r_best_score  <= score_in;
                        r_best_h      <= '0;
                        r_best_v      <= '0;
                        r_exp         <= 10'd1;
                    end else if (score_valid_in) begin
                        frame_err_out <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
